// File: rtl/principal_unit.sv
// principal_unit: 4-input priority/count encoder with registered 2-bit code and 7-segment digit
// Ports: clk, rst (async active-high); e1:e0 mode (00 off, 01 high-prio, 10 low-prio, 11 count);
//        p3..p0 requests; y1:y0 result code; seg_a..seg_g segment drives.
// Macro PRINCIPAL_SEG_ACTIVE_LOW_EN inverts all segments (common-anode); y1:y0 unaffected.
module principal_unit (
  input  logic clk,
  input  logic rst,
  input  logic e1,
  input  logic e0,
  input  logic p3,
  input  logic p2,
  input  logic p1,
  input  logic p0,
  output logic y1,
  output logic y0,
  output logic seg_a,
  output logic seg_b,
  output logic seg_c,
  output logic seg_d,
  output logic seg_e,
  output logic seg_f,
  output logic seg_g
);
`ifdef PRINCIPAL_SEG_ACTIVE_LOW_EN
  localparam logic [6:0] POL = 7'h7f;
`else
  localparam logic [6:0] POL = 7'h00;
`endif
  logic [1:0] m, hi, lo, n_y;
  logic [3:0] p;
  logic [2:0] cnt, dig;
  logic [6:0] font, pat;
  assign m = {e1, e0};
  assign p = {p3, p2, p1, p0};
  always_comb begin
    hi   = p[3] ? 2'd3 : p[2] ? 2'd2 : p[1] ? 2'd1 : 2'd0;
    lo   = p[0] ? 2'd0 : p[1] ? 2'd1 : p[2] ? 2'd2 : p[3] ? 2'd3 : 2'd0;
    cnt  = 3'(p[0]) + 3'(p[1]) + 3'(p[2]) + 3'(p[3]);
    n_y  = m == 2'd1 ? hi : m == 2'd2 ? lo : m == 2'd3 ? cnt[1:0] : 2'd0;
    dig  = m == 2'd3 ? cnt : {1'b0, n_y};
    font = dig == 3'd0 ? 7'b1111110 :
           dig == 3'd1 ? 7'b0110000 :
           dig == 3'd2 ? 7'b1101101 :
           dig == 3'd3 ? 7'b1111001 : 7'b0110011;
    // encoders with no request show a dash; count mode always shows a digit
    pat  = m == 2'd0 ? 7'b0000000 : (m != 2'd3 && p == 4'd0) ? 7'b0000001 : font;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {y1, y0} <= 2'b00;
      {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} <= POL;
    end else begin
      {y1, y0} <= n_y;
      {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} <= pat ^ POL;
    end
endmodule

// File: tb/tb_principal_unit.sv
// tb_principal_unit: directed table, latency, async reset and exhaustive checks for principal_unit
module tb_principal_unit;
`ifdef PRINCIPAL_SEG_ACTIVE_LOW_EN
  localparam logic [6:0] POL = 7'h7f;
`else
  localparam logic [6:0] POL = 7'h00;
`endif
  logic clk = 0, rst = 1;
  logic e1, e0, p3, p2, p1, p0;
  logic y1, y0, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  int compared = 0, mismatched = 0;
  typedef struct { logic [1:0] m; logic [3:0] p; logic [1:0] y; logic [6:0] s; } vec_t;
  vec_t vecs [12];
  principal_unit dut (
    .clk(clk), .rst(rst), .e1(e1), .e0(e0), .p3(p3), .p2(p2), .p1(p1), .p0(p0),
    .y1(y1), .y0(y0), .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      default: return 7'b0110011;
    endcase
  endfunction
  function automatic logic [8:0] model(input logic [1:0] m, input logic [3:0] p);
    int hi = 0, lo = 0, c = 0;
    for (int k = 0; k < 4; k++) if (p[k]) begin hi = k; c++; end
    for (int k = 3; k >= 0; k--) if (p[k]) lo = k;
    case (m)
      2'd0: return {2'b00, 7'b0000000 ^ POL};
      2'd1: return p == 0 ? {2'b00, 7'b0000001 ^ POL} : {2'(hi), glyph(hi) ^ POL};
      2'd2: return p == 0 ? {2'b00, 7'b0000001 ^ POL} : {2'(lo), glyph(lo) ^ POL};
      default: return {2'(c), glyph(c) ^ POL};
    endcase
  endfunction
  task automatic drive(input logic [1:0] m, input logic [3:0] p);
    {e1, e0} = m;
    {p3, p2, p1, p0} = p;
  endtask
  task automatic step(input logic [1:0] m, input logic [3:0] p);
    drive(m, p);
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [1:0] ye, input logic [6:0] se);
    logic [1:0] ya;
    logic [6:0] sa;
    ya = {y1, y0};
    sa = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
    compared++;
    if (ya !== ye || sa !== se) begin
      mismatched++;
      $display("FAIL %s: y=%b seg=%b, expected y=%b seg=%b", name, ya, sa, ye, se);
    end
  endtask
  initial begin
    logic [8:0] exp;
    vecs[0]  = '{2'b01, 4'b0001, 2'b00, 7'b1111110};
    vecs[1]  = '{2'b01, 4'b0110, 2'b10, 7'b1101101};
    vecs[2]  = '{2'b01, 4'b1000, 2'b11, 7'b1111001};
    vecs[3]  = '{2'b01, 4'b0000, 2'b00, 7'b0000001};
    vecs[4]  = '{2'b10, 4'b1010, 2'b01, 7'b0110000};
    vecs[5]  = '{2'b10, 4'b1100, 2'b10, 7'b1101101};
    vecs[6]  = '{2'b10, 4'b1000, 2'b11, 7'b1111001};
    vecs[7]  = '{2'b10, 4'b0000, 2'b00, 7'b0000001};
    vecs[8]  = '{2'b11, 4'b0000, 2'b00, 7'b1111110};
    vecs[9]  = '{2'b11, 4'b0111, 2'b11, 7'b1111001};
    vecs[10] = '{2'b11, 4'b1111, 2'b00, 7'b0110011};
    vecs[11] = '{2'b00, 4'b1011, 2'b00, 7'b0000000};
    drive(2'b11, 4'b1111);
    #2;
    check("reset_before_edge", 2'b00, POL);
    drive(2'b00, 4'b1111);
    rst = 0;
    @(posedge clk);
    #1;
    check("off_after_reset", 2'b00, POL);
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].m, vecs[i].p);
      check($sformatf("vec%0d", i), vecs[i].y, vecs[i].s ^ POL);
    end
    step(2'b01, 4'b1000);
    drive(2'b11, 4'b0000);
    #2;
    check("no_comb_path", 2'b11, 7'b1111001 ^ POL);
    @(posedge clk);
    #1;
    check("registered_update", 2'b00, 7'b1111110 ^ POL);
    for (int i = 0; i < 64; i++) begin
      step(2'(i >> 4), 4'(i));
      exp = model(2'(i >> 4), 4'(i));
      check($sformatf("sweep%0d", i), exp[8:7], exp[6:0]);
      if (i == 29) begin
        #2;
        rst = 1;
        #1;
        check("async_reset_mid", 2'b00, POL);
        @(posedge clk);
        #1;
        check("reset_held", 2'b00, POL);
        rst = 0;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/principal_unit.md
Name: principal_unit

Overview:
- 4-input priority/count encoder with 7-segment readout.
- Mode select e1:e0 picks one of four functions of the 4-bit request vector p3..p0:
  - off
  - highest-priority encode
  - lowest-priority encode
  - population count
- Produces a 2-bit code y1:y0 and drives one 7-segment digit showing the result.
- Sits between switch/request inputs and the board display; all outputs are registered.

Parameters:
- None. Segment polarity is selected by macro; see Optional Feature.

Ports:
- clk    input   1  system clock; all outputs update on its rising edge
- rst    input   1  reset, asynchronous, active-high
- e1     input   1  mode select, MSB
- e0     input   1  mode select, LSB
- p3     input   1  request bit 3 (highest index)
- p2     input   1  request bit 2
- p1     input   1  request bit 1
- p0     input   1  request bit 0 (lowest index)
- y1     output  1  result code, MSB
- y0     output  1  result code, LSB
- seg_a  output  1  7-segment segment a (top)
- seg_b  output  1  segment b (upper right)
- seg_c  output  1  segment c (lower right)
- seg_d  output  1  segment d (bottom)
- seg_e  output  1  segment e (lower left)
- seg_f  output  1  segment f (upper left)
- seg_g  output  1  segment g (middle)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst=1, outputs are forced immediately, independent of clk:
  - y1:y0 = 00
  - all segments off (blank): seg_a..seg_g = 0 in default active-high polarity.
- Inputs are not synchronised internally; they are sampled on each rising clk edge.
- Latency: outputs reflect the mode and request values sampled at the most recent rising edge (1-cycle latency). No combinational path from inputs to outputs.
- Let P = {p3,p2,p1,p0}, M = {e1,e0}.
- M=00 (off): y=00; display blank.
- M=01 (high-priority encode):
  - y = index of the highest set bit of P (p3 wins).
  - Display digit y (0..3).
  - If P=0000: y=00, display dash (seg_g only).
- M=10 (low-priority encode):
  - y = index of the lowest set bit of P (p0 wins).
  - Display digit y.
  - If P=0000: y=00, display dash.
- M=11 (count):
  - Let C = number of set bits in P (0..4).
  - y = C[1:0] (wraps: C=4 gives y=00).
  - Display digit C, 0..4; C=4 shows "4", not "0".
- Segment patterns, active-high, listed segments on, all others off:
  - 0 = a b c d e f
  - 1 = b c
  - 2 = a b d e g
  - 3 = a b c d g
  - 4 = b c f g
  - dash = g
  - blank = none
- Mode change and request change on the same edge: both take effect together; there is no intermediate state.
- Reset deasserted: outputs reflect the first sampled inputs after the first rising edge.
- Reset asserted mid-operation: outputs go to reset values immediately; the prior result is discarded.
- No state other than the output registers; no FSM.

Optional Feature:
- Macro: PRINCIPAL_SEG_ACTIVE_LOW_EN.
- When defined: all seven segment outputs are inverted, for a common-anode display.
  - A lit segment = 0; blank = all 1, including the reset value.
  - y1:y0 are unaffected.
- When undefined: segments are active-high as specified above; reset drives all segments 0.

Test Plan:
- Reset: rst=1 with arbitrary inputs, check before any clk edge -> y=00, seg_a..g=0000000; release rst, M=00, P=1111, one edge -> y=00, segments still blank.
- High-priority sweep: M=01, P=0001 -> y=00, abcdef lit; P=0110 -> y=10, abdeg lit; P=1000 -> y=11, abcdg lit; P=0000 -> y=00, seg_g only.
- Low-priority sweep: M=10, P=1010 -> y=01, b,c lit; P=1100 -> y=10, abdeg lit; P=1000 -> y=11; P=0000 -> dash.
- Count mode: M=11, P=0000 -> y=00, "0"; P=0111 -> y=11, "3"; P=1111 -> y=00, bcfg ("4").
- Exhaustive sweep: all 64 (M,P) combinations, each held one cycle, compared against a reference model one cycle later; also assert rst mid-sweep (async, between edges) -> immediate blank and y=00.
- With PRINCIPAL_SEG_ACTIVE_LOW_EN defined: M=01, P=0001 -> seg a..g = 0000001; reset -> 1111111; y identical to the undefined build.
